// File: rtl/despachador_colas_pkg.sv
// despachador_colas shared definitions:
// FSM state encodings and default sizes.
package despachador_colas_pkg;

    localparam int DC_QUEUE_QUANTITY = 4;
    localparam int DC_DATA_BITS      = 8;
    localparam int DC_CNT_BITS       = 8;

    typedef enum logic [1:0] {
        DC_IDLE    = 2'd0,
        DC_POP     = 2'd1,
        DC_CAPTURE = 2'd2,
        DC_HOLD    = 2'd3
    } dc_state_t;

endpackage

// File: rtl/despachador_colas_contador_saturado.sv
// Saturating up-counter with asynchronous
// active-low clear; holds at all-ones.
module contador_saturado #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    output logic [CNT_BITS-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/despachador_colas.sv
// Grant-driven FIFO dispatcher: pops the granted
// queue, holds the word on a valid/ready port.
module despachador_colas
    import despachador_colas_pkg::*;
#(
    parameter int QUEUE_QUANTITY = DC_QUEUE_QUANTITY,
    parameter int DATA_BITS      = DC_DATA_BITS,
    parameter int CNT_BITS       = DC_CNT_BITS,
    localparam int SEL_BITS =
        (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enb,
    input  logic [SEL_BITS-1:0]                selector,
    input  logic                               selector_enb,
    input  logic [QUEUE_QUANTITY-1:0]          buf_empty,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_data,
    output logic [QUEUE_QUANTITY-1:0]          pop,
    output logic [DATA_BITS-1:0]               data_out,
    output logic                               valid_out,
    input  logic                               ready_in,
    output logic [SEL_BITS-1:0]                queue_out,
    output logic                               busy,
    output logic [QUEUE_QUANTITY*CNT_BITS-1:0] cnt_served,
    output logic                               underflow_err
);

    dc_state_t state, state_nx;

    logic [SEL_BITS-1:0]       sel_q;
    logic [DATA_BITS-1:0]      cur_word;
    logic [QUEUE_QUANTITY-1:0] inc;
    logic req_empty;
    logic cur_empty;
    logic handshake;
    logic accept;

    // Out-of-range selectors match no queue and read as empty.
    always_comb begin
        req_empty = 1'b1;
        cur_empty = 1'b1;
        cur_word  = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (selector == SEL_BITS'(i)) begin
                req_empty = buf_empty[i];
            end
            if (sel_q == SEL_BITS'(i)) begin
                cur_empty = buf_empty[i];
                cur_word  = buf_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign handshake = (state == DC_HOLD) && ready_in;
    assign accept    = enb && selector_enb && !req_empty &&
                       ((state == DC_IDLE) || handshake);
    assign busy      = (state != DC_IDLE);

    always_comb begin
        state_nx = state;
        pop      = '0;
        unique case (state)
            DC_IDLE: begin
                if (accept) state_nx = DC_POP;
            end
            DC_POP: begin
                if (cur_empty) begin
                    state_nx = DC_IDLE;
                end else begin
                    state_nx = DC_CAPTURE;
                    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                        if (sel_q == SEL_BITS'(i)) pop[i] = 1'b1;
                    end
                end
            end
            DC_CAPTURE: state_nx = DC_HOLD;
            DC_HOLD: begin
                if (handshake) state_nx = accept ? DC_POP : DC_IDLE;
            end
            default: state_nx = DC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= DC_IDLE;
            sel_q         <= '0;
            data_out      <= '0;
            queue_out     <= '0;
            valid_out     <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) sel_q <= selector;
            if ((state == DC_POP) && cur_empty) underflow_err <= 1'b1;
            if (state == DC_CAPTURE) begin
                data_out  <= cur_word;
                queue_out <= sel_q;
                valid_out <= 1'b1;
            end
            if (handshake) valid_out <= 1'b0;
        end
    end

    for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_cnt
        assign inc[g] = handshake && (sel_q == SEL_BITS'(g));
        contador_saturado #(
            .CNT_BITS(CNT_BITS)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[g]),
            .count(cnt_served[g*CNT_BITS +: CNT_BITS])
        );
    end

endmodule

// File: tb/tb_despachador_colas.sv
// Self-checking bench for despachador_colas: directed steps
// plus randomized transactions against a per-queue model.
module tb_despachador_colas;

    localparam int QQ = 4;
    localparam int DB = 8;
    localparam int CB = 3;
    localparam int SAT = (1 << CB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enb = 1'b0;
    logic selector_enb = 1'b0;
    logic ready_in = 1'b0;
    logic [1:0] selector = '0;
    logic [QQ-1:0] buf_empty = '1;
    logic [QQ*DB-1:0] buf_data = '0;
    logic [QQ-1:0] pop;
    logic [DB-1:0] data_out;
    logic valid_out;
    logic [1:0] queue_out;
    logic busy;
    logic [QQ*CB-1:0] cnt_served;
    logic underflow_err;

    int passes = 0;
    int fails = 0;
    int total = 0;
    int model [QQ];

    always #5 clk = ~clk;

    despachador_colas #(
        .QUEUE_QUANTITY(QQ),
        .DATA_BITS(DB),
        .CNT_BITS(CB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .selector(selector),
        .selector_enb(selector_enb),
        .buf_empty(buf_empty),
        .buf_data(buf_data),
        .pop(pop),
        .data_out(data_out),
        .valid_out(valid_out),
        .ready_in(ready_in),
        .queue_out(queue_out),
        .busy(busy),
        .cnt_served(cnt_served),
        .underflow_err(underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [QQ*CB-1:0] packed_cnt();
        logic [QQ*CB-1:0] r;
        r = '0;
        for (int i = 0; i < QQ; i++) r[i*CB +: CB] = CB'(model[i]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage(input int q, input bit drop);
        logic [QQ-1:0] e;
        e = QQ'($urandom);
        e[q] = 1'b0;
        buf_empty = e;
        selector = 2'($urandom);
        selector_enb = 1'($urandom);
        enb = drop ? 1'b0 : 1'($urandom);
    endtask

    task automatic start_grant(input int q);
        logic [QQ-1:0] e;
        e = QQ'($urandom);
        e[q] = 1'b0;
        buf_empty = e;
        selector = 2'(q);
        selector_enb = 1'b1;
        enb = 1'b1;
    endtask

    // Runs from the accepting edge up to the cycle before the handshake.
    task automatic deliver(input int q, input logic [DB-1:0] d,
                           input int stall, input bit drop);
        logic [QQ*DB-1:0] w;
        logic [QQ-1:0] one;
        one = '0;
        one[q] = 1'b1;
        step();
        chk("pop_onehot", 32'(pop), 32'(one));
        chk("pop_busy", 32'(busy), 1);
        chk("pop_novalid", 32'(valid_out), 0);
        chk("cnt", 32'(cnt_served), 32'(packed_cnt()));
        garbage(q, drop);
        ready_in = 1'($urandom);
        w = $urandom;
        w[q*DB +: DB] = d;
        buf_data = w;
        step();
        chk("cap_nopop", 32'(pop), 0);
        chk("cap_novalid", 32'(valid_out), 0);
        garbage(q, drop);
        step();
        chk("hold_valid", 32'(valid_out), 1);
        chk("hold_data", 32'(data_out), 32'(d));
        chk("hold_queue", 32'(queue_out), q);
        chk("hold_nopop", 32'(pop), 0);
        for (int s = 0; s < stall; s++) begin
            garbage(q, drop);
            ready_in = 1'b0;
            buf_data = $urandom;
            step();
            chk("stall_valid", 32'(valid_out), 1);
            chk("stall_data", 32'(data_out), 32'(d));
            chk("stall_queue", 32'(queue_out), q);
            chk("stall_nopop", 32'(pop), 0);
        end
        ready_in = 1'b1;
        selector_enb = 1'b0;
        enb = 1'($urandom);
        if (model[q] < SAT) model[q]++;
    endtask

    task automatic finish_idle();
        step();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_novalid", 32'(valid_out), 0);
        chk("idle_cnt", 32'(cnt_served), 32'(packed_cnt()));
        ready_in = 1'($urandom);
        step();
        chk("idle_nopop", 32'(pop), 0);
    endtask

    initial begin
        int q;
        int nq;
        for (int i = 0; i < QQ; i++) model[i] = 0;
        step();
        step();
        chk("rst_pop", 32'(pop), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt_served), 0);
        chk("rst_uf", 32'(underflow_err), 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        start_grant(2);
        ready_in = 1'b1;
        deliver(2, 8'hA5, 0, 1'b0);
        finish_idle();

        start_grant(1);
        deliver(1, 8'h3C, 5, 1'b0);
        finish_idle();

        for (int k = 0; k < QQ; k++) begin
            start_grant(k);
            deliver(k, DB'(8'h10 + k), 0, 1'b0);
        end
        finish_idle();
        chk("b2b_cnt", 32'(cnt_served), 32'(packed_cnt()));

        buf_empty = 4'b1000;
        selector = 2'd3;
        selector_enb = 1'b1;
        enb = 1'b1;
        step();
        step();
        chk("empty_nopop", 32'(pop), 0);
        chk("empty_busy", 32'(busy), 0);
        buf_empty = '0;
        enb = 1'b0;
        step();
        step();
        chk("enb0_nopop", 32'(pop), 0);
        chk("enb0_busy", 32'(busy), 0);
        start_grant(0);
        deliver(0, 8'h5A, 1, 1'b1);
        finish_idle();

        for (int k = 0; k < SAT + 2; k++) begin
            start_grant(1);
            deliver(1, DB'($urandom), 0, 1'b0);
        end
        finish_idle();
        chk("sat_cnt1", 32'(cnt_served[1*CB +: CB]), SAT);

        start_grant(0);
        step();
        buf_empty[0] = 1'b1;
        selector_enb = 1'b0;
        #1;
        chk("uf_nopop", 32'(pop), 0);
        step();
        chk("uf_flag", 32'(underflow_err), 1);
        chk("uf_idle", 32'(busy), 0);
        chk("uf_novalid", 32'(valid_out), 0);
        chk("uf_cnt", 32'(cnt_served), 32'(packed_cnt()));

        q = $urandom_range(0, QQ - 1);
        start_grant(q);
        for (int n = 0; n < 40; n++) begin
            deliver(q, DB'($urandom), $urandom_range(0, 3), 1'b0);
            nq = $urandom_range(0, QQ - 1);
            if (n == 39) begin
                finish_idle();
            end else if ($urandom_range(0, 3) != 0) begin
                start_grant(nq);
            end else begin
                finish_idle();
                start_grant(nq);
                buf_empty[nq] = 1'b1;
                enb = 1'($urandom);
                step();
                chk("rej_busy", 32'(busy), 0);
                start_grant(nq);
            end
            q = nq;
        end
        chk("uf_sticky", 32'(underflow_err), 1);

        start_grant(3);
        deliver(3, 8'hC3, 0, 1'b0);
        ready_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_pop", 32'(pop), 0);
        chk("arst_data", 32'(data_out), 0);
        chk("arst_queue", 32'(queue_out), 0);
        chk("arst_cnt", 32'(cnt_served), 0);
        chk("arst_uf", 32'(underflow_err), 0);
        for (int i = 0; i < QQ; i++) model[i] = 0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_nopop", 32'(pop), 0);
        chk("rel_busy", 32'(busy), 0);
        start_grant(2);
        deliver(2, 8'h77, 0, 1'b0);
        finish_idle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
